// File: rtl/pow8_pipeline_parameterization_pkg.sv
// Shared constants and types for the pipelined x^(2^LATENCY) unit.
package pow8_pkg;

    localparam int unsigned DATA_IN_W       = 7;
    localparam int unsigned DATA_OUT_W      = 64;
    localparam int unsigned LATENCY_DEFAULT = 3;

    typedef logic [DATA_OUT_W-1:0] stage_word_t;

endpackage

// File: rtl/pow8_pipeline_parameterization_if.sv
// Streaming operand/result bus of the pow8 unit (no backpressure).
interface pow8_if;
    import pow8_pkg::*;

    logic [DATA_IN_W-1:0] i_data;
    logic                 i_valid;
    logic                 o_valid;
    stage_word_t          o_data;

    modport master (output i_data, output i_valid, input o_valid, input o_data);
    modport slave  (input i_data, input i_valid, output o_valid, output o_data);
endinterface

// File: rtl/pow8_pipeline_parameterization_square_stage.sv
// One registered squaring stage; data only updates when the incoming word is valid.
module pow8_square_stage
    import pow8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  stage_word_t data_i,
    output logic        valid_o,
    output stage_word_t data_o
);

    logic        valid_q;
    stage_word_t data_q;
    stage_word_t data_d;

    // Low 64 bits of the square.
    always_comb begin
        data_d = data_i * data_i;
    end

    // Valid shifts every cycle; data holds across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pow8_pipeline_parameterization.sv
// Fully pipelined x^(2^LATENCY) unit built from LATENCY squaring stages.
// Optional simulation completion monitor: define POW8_DONE_MONITOR_EN.
module pow8_pipeline_parameterization
    import pow8_pkg::*;
#(
    parameter int unsigned LATENCY    = LATENCY_DEFAULT,
    parameter int unsigned TEST_TIMES = 100
) (
    input  logic   clk,
    input  logic   rst_n,
    pow8_if.slave  bus
);

    logic [LATENCY:0] valid_s;
    stage_word_t      data_s [0:LATENCY];

    // Stage 0 is the raw operand, zero-extended.
    assign valid_s[0] = bus.i_valid;
    assign data_s[0]  = DATA_OUT_W'(bus.i_data);

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        pow8_square_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (valid_s[k]),
            .data_i  (data_s[k]),
            .valid_o (valid_s[k+1]),
            .data_o  (data_s[k+1])
        );
    end

    assign bus.o_valid = valid_s[LATENCY];
    assign bus.o_data  = data_s[LATENCY];

`ifdef POW8_DONE_MONITOR_EN
    logic [31:0] done_cnt_q;

    // Count results and announce once when the expected total is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= 32'd0;
        end else if (bus.o_valid) begin
            done_cnt_q <= done_cnt_q + 32'd1;
            if (done_cnt_q + 32'd1 == 32'(TEST_TIMES)) begin
                $display("pow8 done: %0d results at time %0t", done_cnt_q + 32'd1, $time);
            end
        end
    end
`else
    // TEST_TIMES only matters to the completion monitor.
    logic unused_test_times;
    assign unused_test_times = ^32'(TEST_TIMES);
`endif

endmodule

// File: tb/tb_pow8_pipeline_parameterization.sv
// Self-checking bench for pow8_pipeline_parameterization (default LATENCY = 3).
module tb_pow8_pipeline_parameterization;
    import pow8_pkg::*;

    localparam int unsigned LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    pow8_if bus ();

    pow8_pipeline_parameterization #(.LATENCY(LAT), .TEST_TIMES(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: applied samples per edge, plus the held output word.
    bit              hist_v [$];
    longint unsigned hist_d [$];
    longint unsigned hold_d;

    typedef struct {
        bit              v;
        int              d;
        bit              exp_v;
        longint unsigned exp_d;
    } vec_t;

    vec_t tbl [$];

    function automatic longint unsigned ref_pow(input int x);
        longint unsigned r = 1;
        for (int i = 0; i < (1 << LAT); i++) r = r * longint'(x);
        return r;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        hist_v.delete();
        hist_d.delete();
        hold_d = 0;
    endtask

    // Drive one sample, advance an edge, compare against the model.
    task automatic cycle(input bit v, input int d, input string name);
        bit              ev;
        bus.i_valid = v;
        bus.i_data  = DATA_IN_W'(d);
        @(posedge clk);
        hist_v.push_back(v);
        hist_d.push_back(ref_pow(d));
        ev = 1'b0;
        if (hist_v.size() >= LAT) begin
            int idx = hist_v.size() - LAT;
            ev = hist_v[idx];
            if (ev) hold_d = hist_d[idx];
        end
        @(negedge clk);
        check({name, ".valid"}, longint'(bus.o_valid), longint'(ev));
        check({name, ".data"}, bus.o_data, hold_d);
    endtask

    task automatic quick_reset();
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        // Reset held with a live-looking input.
        rst_n       = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = DATA_IN_W'(5);
        model_clear();
        #1;
        check("rst_t0.valid", longint'(bus.o_valid), 0);
        check("rst_t0.data", bus.o_data, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_hold.valid", longint'(bus.o_valid), 0);
            check("rst_hold.data", bus.o_data, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 5, "rst_release");
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, "rst_flush");

        // Table: single sample, bubbles, max operand.
        quick_reset();
        tbl.push_back('{1, 2, 0, 0});
        tbl.push_back('{0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 256});
        tbl.push_back('{0, 0, 0, 256});
        tbl.push_back('{1, 3, 0, 256});
        tbl.push_back('{0, 9, 0, 256});
        tbl.push_back('{1, 4, 1, 6561});
        tbl.push_back('{1, 5, 0, 6561});
        tbl.push_back('{0, 7, 1, 65536});
        tbl.push_back('{0, 0, 1, 390625});
        tbl.push_back('{0, 0, 0, 390625});
        tbl.push_back('{0, 0, 0, 390625});
        tbl.push_back('{1, 127, 0, 390625});
        tbl.push_back('{0, 0, 0, 390625});
        tbl.push_back('{0, 0, 1, 64'd67675234241018881});
        tbl.push_back('{0, 0, 0, 64'd67675234241018881});
        foreach (tbl[i]) begin
            bus.i_valid = tbl[i].v;
            bus.i_data  = DATA_IN_W'(tbl[i].d);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl[%0d].valid", i), longint'(bus.o_valid), longint'(tbl[i].exp_v));
            check($sformatf("tbl[%0d].data", i), bus.o_data, tbl[i].exp_d);
        end

        // Streaming 0..99 back to back.
        quick_reset();
        for (int i = 0; i < 100; i++) cycle(1'b1, i, "stream");
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, "stream_tail");
        check("stream_last_99", bus.o_data, 64'd9227446944279201);
        check("stream_hi_byte", longint'(bus.o_data[63:56]), 0);

        // Asynchronous reset with samples in flight.
        cycle(1'b1, 10, "mid_fill");
        cycle(1'b1, 11, "mid_fill");
        cycle(1'b1, 12, "mid_fill");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.valid", longint'(bus.o_valid), 0);
        check("mid_rst.data", bus.o_data, 0);
        model_clear();
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, "mid_after");

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), "rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout at %0t: got no finish, expected finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/pow8_pipeline_parameterization.md
Name: pow8_pipeline_parameterization

Overview:
- Fully pipelined 8th-power unit: o_data = i_data^8, one result per clock, fixed latency.
- Built as a chain of LATENCY registered squaring stages (x -> x^2 -> x^4 -> x^8).
- A valid bit travels alongside the data.
- Sits as a streaming arithmetic kernel with no backpressure; the upstream may present a new sample every cycle.

Parameters:
- LATENCY, 3, number of registered squaring stages. Result = i_data^(2^LATENCY), truncated to 64 bits. The default of 3 gives x^8. Legal range 1..6.
- TEST_TIMES, 100, expected number of valid samples per run. Used only by the optional completion monitor; no effect on datapath RTL.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_data  input  7  unsigned operand x
- i_valid  input  1  i_data is valid this cycle
- o_valid  output  1  o_data holds a new result this cycle
- o_data  output  64  unsigned x^(2^LATENCY), zero-extended

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: all stage valid bits = 0, all stage data registers = 0, so o_valid = 0 and o_data = 0. Reset takes effect immediately without waiting for clk.
- Stage 0 input: x zero-extended to 64 bits.
- Stage k (1..LATENCY): on a rising clk edge, if valid[k-1] = 1 then data[k] <= data[k-1] * data[k-1] (64x64 multiply, low 64 bits kept) and valid[k] <= 1. Otherwise valid[k] <= 0 and data[k] holds its value.
- valid[0] = i_valid and data[0] = i_data. Valid shifts every cycle, unconditionally.
- Outputs: o_valid = valid[LATENCY] and o_data = data[LATENCY], both registered with no combinational path from inputs.
- Latency: a sample presented with i_valid = 1 at edge N appears with o_valid = 1 after edge N+LATENCY (3 cycles by default).
- Throughput: 1 sample per cycle. Back-to-back valid samples emerge back-to-back in order.
- Bubbles: i_valid = 0 cycles propagate as o_valid = 0 cycles at the same distance. o_data holds the last valid result during bubbles and is not cleared.
- Width: with a 7-bit input and LATENCY = 3 the maximum is 127^8 = 67675234241018881 < 2^56, so there is no truncation. Bits 63:56 are always 0.
- Reset mid-stream: all in-flight samples are discarded. After release the first o_valid occurs LATENCY cycles after the first new i_valid.
- No ready/stall input exists, so the consumer must accept every o_valid pulse.

Optional Feature:
- Macro: POW8_DONE_MONITOR_EN.
- When defined: a simulation-only 32-bit counter increments on each clk edge where o_valid = 1 (cleared by rst_n). When the count reaches TEST_TIMES it issues a single $display of the count and $time.
- When undefined: no counter and no display; the module is pure datapath and identical in function.

Decomposition:
- Shared package pow8_pkg holds:
  - constants DATA_IN_W = 7 and DATA_OUT_W = 64;
  - the default LATENCY = 3;
  - a typedef for the 64-bit stage word.
- One natural sub-module, pow8_square_stage: registered x^2 with valid in/out, enable on valid, asynchronous active-low reset.
- The top instantiates LATENCY copies of pow8_square_stage in a generate loop.

Test Plan:
- Reset: hold rst_n = 0 with i_valid = 1 and i_data = 5 -> o_valid = 0 and o_data = 0 throughout reset; no output appears until LATENCY cycles after release.
- Single sample: i_data = 2 with i_valid = 1 for one cycle -> exactly one o_valid pulse 3 cycles later with o_data = 256. o_data then holds 256 while o_valid = 0.
- Streaming: i_data = 0..99 on consecutive cycles with i_valid = 1 -> 100 consecutive o_valid cycles in order. o_data values include 0, 1, 256, 6561 and, for input 99, 9227446944279201. With POW8_DONE_MONITOR_EN defined, the monitor fires once at the 100th result.
- Max operand: i_data = 127 -> o_data = 67675234241018881 after 3 cycles.
- Bubbles: valid pattern 1,0,1,1,0 with data 3,x,4,5,x -> o_valid pattern 1,0,1,1,0 shifted by 3 cycles, with o_data 6561, (held 6561), 65536, 390625, (held 390625).
- Reset mid-stream: assert rst_n = 0 asynchronously while 3 samples are in flight -> o_valid drops to 0 immediately and the in-flight samples never appear after reset release.
